// File: rtl/rf_xfer_pkg.sv
// rtl/rf_xfer_pkg.sv - shared types and default widths for the register-file spill/fill engine
package rf_xfer_pkg;

  localparam int RF_W = 8;
  localparam int RF_A = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPILL_RD,
    ST_SPILL_SEND,
    ST_FILL,
    ST_DONE
  } rf_xfer_state_t;

endpackage

// File: rtl/rf_addr_walker.sv
// rtl/rf_addr_walker.sv - register pointer and range end for the spill/fill walk
module rf_addr_walker
  import rf_xfer_pkg::*;
#(
  parameter int A = RF_A
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [A-1:0] i_first,
  input  logic [A-1:0] i_last,
  input  logic         i_advance,
  output logic [A-1:0] o_ptr,
  output logic         o_is_last
);

  logic [A-1:0] r_ptr;
  logic [A-1:0] r_last;
  logic [A-1:0] w_ptr_inc;

  // Natural A-bit overflow gives the wrap from 2**A-1 back to 0.
  assign w_ptr_inc = r_ptr + {{(A-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_ptr  <= i_first;
      r_last <= i_last;
    end else if (i_advance) begin
      r_ptr  <= w_ptr_inc;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_is_last = (r_ptr == r_last);

endmodule

// File: rtl/rf_spill_fill.sv
// rtl/rf_spill_fill.sv - register-file context save/restore engine (spill to stream, fill from stream)
module rf_spill_fill
  import rf_xfer_pkg::*;
#(
  parameter int W = RF_W,
  parameter int A = RF_A
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_spill_start,
  input  logic         i_fill_start,
  input  logic [A-1:0] i_reg_first,
  input  logic [A-1:0] i_reg_last,
  output logic         o_busy,
  output logic         o_done,
  output logic [A-1:0] o_rf_raddr,
  input  logic [W-1:0] i_rf_rdata,
  output logic         o_rf_write_en,
  output logic [A-1:0] o_rf_waddr,
  output logic [W-1:0] o_rf_wdata,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data
);

  rf_xfer_state_t r_state;
  rf_xfer_state_t w_state_next;
  logic [W-1:0]   r_out_data;
  logic           w_load;
  logic           w_advance;
  logic [A-1:0]   w_ptr;
  logic           w_is_last;
  logic           w_fill_accept;
  logic           w_spilling;

  rf_addr_walker #(.A(A)) u_walker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_first   (i_reg_first),
    .i_last    (i_reg_last),
    .i_advance (w_advance),
    .o_ptr     (w_ptr),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Spill has priority when both starts arrive together.
        if (i_spill_start) begin
          w_state_next = ST_SPILL_RD;
          w_load       = 1'b1;
        end else if (i_fill_start) begin
          w_state_next = ST_FILL;
          w_load       = 1'b1;
        end
      end
      ST_SPILL_RD: w_state_next = ST_SPILL_SEND;
      ST_SPILL_SEND: begin
        if (i_out_ready) begin
          if (w_is_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_SPILL_RD;
            w_advance    = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (i_in_valid) begin
          if (w_is_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data <= '0;
    end else if (r_state == ST_SPILL_RD) begin
      r_out_data <= i_rf_rdata;
    end
  end

  assign w_spilling    = (r_state == ST_SPILL_RD) || (r_state == ST_SPILL_SEND);
  assign w_fill_accept = (r_state == ST_FILL) && i_in_valid;

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_out_valid   = (r_state == ST_SPILL_SEND);
  assign o_out_data    = r_out_data;
  assign o_in_ready    = (r_state == ST_FILL);
  assign o_rf_raddr    = w_spilling ? w_ptr : '0;
  // Write port is forced to zero unless a fill beat is being accepted.
  assign o_rf_write_en = w_fill_accept;
  assign o_rf_waddr    = w_fill_accept ? w_ptr : '0;
  assign o_rf_wdata    = w_fill_accept ? i_in_data : '0;

endmodule

// File: tb/tb_rf_spill_fill.sv
// tb/tb_rf_spill_fill.sv - directed scoreboard bench for rf_spill_fill
module tb_rf_spill_fill;

  logic       clk;
  logic       rst_n;
  logic       i_spill_start;
  logic       i_fill_start;
  logic [3:0] i_reg_first;
  logic [3:0] i_reg_last;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_rf_raddr;
  logic [7:0] i_rf_rdata;
  logic       o_rf_write_en;
  logic [3:0] o_rf_waddr;
  logic [7:0] o_rf_wdata;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [7:0] o_out_data;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;

  rf_spill_fill #(.W(8), .A(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_spill_start (i_spill_start),
    .i_fill_start  (i_fill_start),
    .i_reg_first   (i_reg_first),
    .i_reg_last    (i_reg_last),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rf_raddr    (o_rf_raddr),
    .i_rf_rdata    (i_rf_rdata),
    .o_rf_write_en (o_rf_write_en),
    .o_rf_waddr    (o_rf_waddr),
    .o_rf_wdata    (o_rf_wdata),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_data     (i_in_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;

  logic [7:0]  rf [16];
  logic [7:0]  exp_rf [16];
  logic        tb_wr;
  logic [3:0]  tb_waddr;
  logic [7:0]  tb_wdata;
  logic [7:0]  bq [$];
  logic [11:0] wq [$];
  int          beat_cyc [$];

  assign i_rf_rdata = rf[o_rf_raddr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_wr) rf[tb_waddr] <= tb_wdata;
    else if (o_rf_write_en) rf[o_rf_waddr] <= o_rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inrdy_outvld_excl", {31'd0, o_in_ready && o_out_valid}, 0);
      chk("wen_only_on_accept", {31'd0, o_rf_write_en && !(o_in_ready && i_in_valid)}, 0);
      if (!o_rf_write_en) chk("idle_wport_zero", {20'd0, o_rf_waddr, o_rf_wdata}, 0);
      if (o_rf_write_en) begin
        chk("wr_expected", {31'd0, wq.size() != 0}, 1);
        if (wq.size() != 0) chk("wr_addr_data", {20'd0, o_rf_waddr, o_rf_wdata}, {20'd0, wq.pop_front()});
      end
      if (o_out_valid && i_out_ready) begin
        beat_cyc.push_back(cyc);
        chk("beat_expected", {31'd0, bq.size() != 0}, 1);
        if (bq.size() != 0) chk("beat_data", {24'd0, o_out_data}, {24'd0, bq.pop_front()});
      end
      if (o_done) begin
        done_count++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
    exp_rf[a] = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic start_op(input logic sp, input logic fl, input logic [3:0] first, input logic [3:0] last);
    @(posedge clk); #1;
    i_spill_start = sp; i_fill_start = fl; i_reg_first = first; i_reg_last = last;
    @(posedge clk); #1;
    i_spill_start = 1'b0; i_fill_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_done) begin got = 1'b1; break; end
    end
    chk("done_seen", {31'd0, got}, 1);
    @(posedge clk); #1;
  endtask

  task automatic spill_beat(input int hold);
    logic       seen;
    logic [7:0] d0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_out_valid) begin seen = 1'b1; break; end
    end
    chk("beat_valid_seen", {31'd0, seen}, 1);
    d0 = o_out_data;
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", {31'd0, o_out_valid}, 1);
      chk("hold_data", {24'd0, o_out_data}, {24'd0, d0});
    end
    @(posedge clk); #1; i_out_ready = 1'b1;
    @(posedge clk); #1; i_out_ready = 1'b0;
  endtask

  task automatic fill_beat(input logic [3:0] a, input logic [7:0] d, input int gap);
    logic acc;
    repeat (gap) begin @(posedge clk); #1; end
    i_in_valid = 1'b1; i_in_data = d;
    wq.push_back({a, d});
    exp_rf[a] = d;
    acc = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_in_ready) begin acc = 1'b1; @(posedge clk); #1; break; end
    end
    chk("fill_accepted", {31'd0, acc}, 1);
    i_in_valid = 1'b0; i_in_data = 8'h00;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, {24'd0, rf[i]}, {24'd0, exp_rf[i]});
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {22'd0, o_busy, o_done, o_out_valid, o_in_ready, o_rf_write_en, 5'd0},
        32'd0);
    chk(tag, {20'd0, o_rf_raddr, o_rf_waddr}, 32'd0);
    chk(tag, {16'd0, o_out_data, o_rf_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dc;
    rst_n = 1'b0; tb_wr = 1'b0; tb_waddr = 4'd0; tb_wdata = 8'd0;
    i_spill_start = 1'b0; i_fill_start = 1'b0; i_reg_first = 4'd0; i_reg_last = 4'd0;
    i_out_ready = 1'b0; i_in_valid = 1'b0; i_in_data = 8'd0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset_values");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) poke(4'(i), (i < 4) ? 8'(8'h11 * (i + 1)) : 8'(8'hC0 + i));

    // Spill R0..R3 with the sink always ready.
    i_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) bq.push_back(exp_rf[j]);
    beat_cyc.delete();
    start_op(1'b1, 1'b0, 4'd0, 4'd3);
    k = cyc;
    @(negedge clk);
    chk("busy_after_start", {31'd0, o_busy}, 1);
    wait_done(40);
    chk("spill4_done_cycle", last_done_cyc, k + 8);
    chk("spill4_beat_count", beat_cyc.size(), 4);
    for (int j = 0; j < 4 && j < beat_cyc.size(); j++) chk("spill4_beat_cycle", beat_cyc[j], k + 1 + 2 * j);
    chk("spill4_queue_empty", bq.size(), 0);

    // Back-pressure on the second beat.
    i_out_ready = 1'b0;
    for (int j = 4; j < 7; j++) bq.push_back(exp_rf[j]);
    start_op(1'b1, 1'b0, 4'd4, 4'd6);
    for (int j = 0; j < 3; j++) spill_beat((j == 1) ? 3 : 0);
    wait_done(20);
    chk("bp_queue_empty", bq.size(), 0);

    // Both starts together, plus stray starts mid-spill.
    i_out_ready = 1'b1;
    bq.push_back(exp_rf[8]); bq.push_back(exp_rf[9]);
    dc = done_count;
    start_op(1'b1, 1'b1, 4'd8, 4'd9);
    i_spill_start = 1'b1; i_fill_start = 1'b1;
    @(posedge clk); #1;
    i_spill_start = 1'b0; i_fill_start = 1'b0;
    wait_done(20);
    repeat (4) @(posedge clk); #1;
    chk("single_done", done_count, dc + 1);
    chk("idle_after_spill", {31'd0, o_busy}, 0);
    chk("prio_queue_empty", bq.size(), 0);

    // Wrapping fill 14..1 with gaps.
    start_op(1'b0, 1'b1, 4'd14, 4'd1);
    fill_beat(4'd14, 8'hA0, 0);
    fill_beat(4'd15, 8'hA1, 2);
    fill_beat(4'd0,  8'hA2, 1);
    fill_beat(4'd1,  8'hA3, 3);
    @(negedge clk);
    chk("wrap_done_next", {31'd0, o_done}, 1);
    @(posedge clk); #1;
    check_rf("wrap_fill_rf");
    chk("wrap_wq_empty", wq.size(), 0);

    // Reset in the middle of a fill.
    start_op(1'b0, 1'b1, 4'd0, 4'd15);
    fill_beat(4'd0, 8'h5A, 0);
    fill_beat(4'd1, 8'h5B, 0);
    i_in_valid = 1'b1; i_in_data = 8'hEE;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midfill_reset");
    i_in_valid = 1'b0; i_in_data = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_rf("midfill_rf");

    // Single-register spill, then full-file fill.
    i_out_ready = 1'b1;
    beat_cyc.delete();
    bq.push_back(exp_rf[7]);
    start_op(1'b1, 1'b0, 4'd7, 4'd7);
    k = cyc;
    wait_done(20);
    chk("single_done_cycle", last_done_cyc, k + 2);
    chk("single_beat_count", beat_cyc.size(), 1);
    if (beat_cyc.size() > 0) chk("single_beat_cycle", beat_cyc[0], k + 1);
    start_op(1'b0, 1'b1, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) fill_beat(4'(i), 8'(i * 7 + 3), 0);
    @(negedge clk);
    chk("full_done_next", {31'd0, o_done}, 1);
    @(posedge clk); #1;
    check_rf("full_fill_rf");
    chk("final_bq_empty", bq.size(), 0);
    chk("final_wq_empty", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
